pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined MIPS core (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of the destination and source register info for the EX, MEM and WB stages.
- From that state it produces the PC/IF-ID hold, the ID/EX bubble, the branch flushes and the ALU operand-forwarding selects.
- Sits beside the control unit; drives the enables of the PC, IF/ID and ID/EX registers and the select lines of the ALU input forwarding muxes.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  RA_W  rs field (instruction[25:21]) of the ID instruction.
- id_rt  input  RA_W  rt field (instruction[20:16]) of the ID instruction.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_wen  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load (LW).
- id_dst  input  RA_W  destination after the RegDst mux (rt or rd).
- ex_br_taken  input  1  branch in EX resolved taken (BEQ with zero=1).
- pc_hold  output  1  hold the PC.
- ifid_hold  output  1  hold the IF/ID register.
- idex_bubble  output  1  load a NOP into ID/EX.
- ifid_flush  output  1  clear IF/ID to a NOP.
- fwd_a  output  2  ALU A source select for the EX instruction.
- fwd_b  output  2  ALU B source select for the EX instruction.
- stall_cnt  output  CNT_W  number of load-use stall cycles.
- flush_cnt  output  CNT_W  number of taken-branch flush events.

Behaviour:
- Reset (rst=0, asynchronous): all stage valids, destination fields and both counters go to 0. Outputs are then 0, fwd_a/fwd_b = 2'b00, no hold, no flush.
- Internal stage records:
  - EX record: {valid, rs, rt, use_rs, use_rt, wen, memread, dst}.
  - MEM record: {valid, wen, memread, dst}.
  - WB record: {valid, wen, dst}.
- A record "writes r" when valid & wen & dst==r & r!=0. Register 0 never triggers a hazard or a forward.
- load_use (combinational) is asserted when all of the following hold:
  - id_valid;
  - the EX record is a valid load (memread & wen);
  - either (id_use_rs & EX writes id_rs) or (id_use_rt & EX writes id_rt).
- Priority: ex_br_taken over load_use.
- ex_br_taken=1:
  - ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0.
  - flush_cnt increments by 1 and saturates at all-ones.
- Else if load_use=1:
  - pc_hold=1, ifid_hold=1, idex_bubble=1.
  - stall_cnt increments by 1 and saturates at all-ones.
  - A stall is exactly one cycle. On the next cycle the load is in MEM, so load_use deasserts.
- Else: all four control outputs are 0.
- Stage advance on every rising edge (the pipeline never freezes below ID):
  - WB record <= MEM record; MEM record <= EX record.
  - EX record <= all-zero bubble if idex_bubble, otherwise the ID inputs, with valid = id_valid.
- Forwarding (combinational from the records; operand A uses the EX record's rs/use_rs, operand B its rt/use_rt):
  - 2'b10: MEM writes the operand register and MEM is not a load (forward the EX/MEM ALU result).
  - else 2'b01: WB writes the operand register (forward the WB write data: load data or ALU result).
  - else 2'b00: register file output.
  - 2'b11 is never driven.
- MEM outranks WB, so the youngest producer wins.
- If the operand is not used, the select is 2'b00.
- fwd_b chooses between register-file data and forwarded data for rt. It sits before the ALUSrc immediate mux and also feeds SW store data.
- Same-cycle WB write and ID read of the same register is resolved by the register file (write-first). This block does not handle it.
- The counters are free-running and are cleared only by reset.
- A reset assertion mid-stall or mid-flush clears everything immediately. The first cycle after release behaves as an empty pipeline.

Test Plan:
- Reset:
  - Stimulus: rst=0 at t0 with random inputs.
  - Required: every output is 0 asynchronously, before any clock edge.
  - After release with id_valid=0 for 5 cycles, outputs stay 0.
- Load-use stall:
  - Stimulus: "LW r5" is issued (id_memread=1, id_wen=1, id_dst=5). Next cycle, ID holds "ADD r6,r5,r2" (id_rs=5, id_use_rs=1).
  - Required: pc_hold=ifid_hold=idex_bubble=1 for exactly one cycle; stall_cnt goes 0->1.
  - When the ADD reaches EX, fwd_a=2'b01.
- EX/MEM forwarding:
  - Stimulus: "ADD r3,r1,r2" followed by "SUB r4,r3,r3".
  - Required: no stall; while the SUB is in EX, fwd_a=fwd_b=2'b10.
- Priority and register 0:
  - Stimulus: ADD writes r7, ADD writes r7, then "OR r8,r7,r0".
  - Required: fwd_a=2'b10 (younger MEM producer wins over WB); fwd_b=2'b00 (r0 never forwarded).
  - Stimulus: a LW with id_dst=0, followed by a reader of r0.
  - Required: no stall.
- Branch beats stall:
  - Stimulus: ex_br_taken=1 in the same cycle as a load_use condition.
  - Required: ifid_flush=1, idex_bubble=1, pc_hold=0; flush_cnt increments; stall_cnt unchanged.
- Counter saturation and mid-stall reset:
  - Stimulus: with CNT_W=4, force 20 load-use stalls.
  - Required: stall_cnt holds at 15.
  - Stimulus: assert rst during a stall cycle.
  - Required: pc_hold drops immediately and stall_cnt reads 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface bundling the ID-stage instruction info, the EX branch outcome and
// the hazard/forwarding controls that go back to the datapath.
//
// master : datapath side (drives ID info and ex_br_taken, consumes controls)
// slave  : pipeline_hazard_ctrl (consumes ID info, drives controls/counters)
//
// Signals
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_memread, id_dst
//   ex_br_taken
//   pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b
//   stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) ();

  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wen;
  logic             id_memread;
  logic [RA_W-1:0]  id_dst;
  logic             ex_br_taken;

  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_memread, id_dst,
    output ex_br_taken,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_memread, id_dst,
    input  ex_br_taken,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, fwd_a, fwd_b,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
//
// Keeps a shadow record of the instructions in EX, MEM and WB and derives:
//   - load-use stall   : pc_hold, ifid_hold, idex_bubble
//   - taken-branch kill: ifid_flush, idex_bubble (wins over a stall)
//   - ALU operand forwarding selects fwd_a / fwd_b
//       2'b10 EX/MEM ALU result, 2'b01 WB write data, 2'b00 register file
//   - saturating stall / flush event counters
//
// Ports
//   clk    pipeline clock, rising edge
//   rst    asynchronous active-low reset
//   hz_io  slave side of pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  hz_io
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic            wen;
    logic            memread;
    logic [RA_W-1:0] dst;
  } ex_rec_t;

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic            memread;
    logic [RA_W-1:0] dst;
  } mem_rec_t;

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic [RA_W-1:0] dst;
  } wb_rec_t;

  ex_rec_t          ex_q, ex_d;
  mem_rec_t         mem_q, mem_d;
  wb_rec_t          wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             load_use;
  logic             br_taken;
  logic             pc_hold, ifid_hold, idex_bubble, ifid_flush;
  logic [1:0]       fwd_a, fwd_b;

  // A stage record produces register r; r0 is hard-wired and never produced.
  function automatic logic writes_reg(input logic            valid,
                                      input logic            wen,
                                      input logic [RA_W-1:0] dst,
                                      input logic [RA_W-1:0] r);
    return valid & wen & (dst == r) & (r != '0);
  endfunction

  // MEM beats WB so the youngest producer wins; a load in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input logic            use_op,
                                         input logic [RA_W-1:0] r,
                                         input mem_rec_t        mem,
                                         input wb_rec_t         wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_op) begin
      if (writes_reg(mem.valid, mem.wen, mem.dst, r) && !mem.memread) begin
        sel = 2'b10;
      end else if (writes_reg(wb.valid, wb.wen, wb.dst, r)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    if (hz_io.id_valid && ex_q.valid && ex_q.memread && ex_q.wen) begin
      load_use = (hz_io.id_use_rs && writes_reg(ex_q.valid, ex_q.wen, ex_q.dst, hz_io.id_rs)) ||
                 (hz_io.id_use_rt && writes_reg(ex_q.valid, ex_q.wen, ex_q.dst, hz_io.id_rt));
    end
  end

  // ex_br_taken is a raw datapath input; gate it so every control is quiet
  // while reset is asserted, independent of what the datapath drives.
  assign br_taken = rst & hz_io.ex_br_taken;

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    fwd_a = fwd_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b = fwd_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  // ---------------------------------------------------------------------------
  // Stage advance and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d = '0;
    if (!idex_bubble) begin
      ex_d.valid   = hz_io.id_valid;
      ex_d.rs      = hz_io.id_rs;
      ex_d.rt      = hz_io.id_rt;
      ex_d.use_rs  = hz_io.id_use_rs;
      ex_d.use_rt  = hz_io.id_use_rt;
      ex_d.wen     = hz_io.id_wen;
      ex_d.memread = hz_io.id_memread;
      ex_d.dst     = hz_io.id_dst;
    end

    mem_d.valid   = ex_q.valid;
    mem_d.wen     = ex_q.wen;
    mem_d.memread = ex_q.memread;
    mem_d.dst     = ex_q.dst;

    wb_d.valid = mem_q.valid;
    wb_d.wen   = mem_q.wen;
    wb_d.dst   = mem_q.dst;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (br_taken) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (load_use) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hz_io.pc_hold     = pc_hold;
  assign hz_io.ifid_hold   = ifid_hold;
  assign hz_io.idex_bubble = idex_bubble;
  assign hz_io.ifid_flush  = ifid_flush;
  assign hz_io.fwd_a       = fwd_a;
  assign hz_io.fwd_b       = fwd_b;
  assign hz_io.stall_cnt   = stall_cnt_q;
  assign hz_io.flush_cnt   = flush_cnt_q;

endmodule
